tlb_pipe: RTL and testbench

Parametrised, pipelined successor to the 16-entry fully-associative TLB in the core's MMU. Entry count is a parameter, and both search ports return registered results one cycle after a request. Lookups qualify on the entry-valid bit and report multi-hit. INVTLB takes dedicated operands, and an internal round-robin counter supplies the TLBFILL replacement index. It sits between IF/EX address generation and the CSR unit (TLBRD/TLBWR/TLBFILL/TLBSRCH/INVTLB).

---
 rtl/tlb_pipe.sv | 256 +++++++++++++++++++++++++
 tb/tb_tlb_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_pipe.sv
// Parametrised fully-associative TLB with two registered search ports, INVTLB,
// round-robin TLBFILL victim selection and a combinational read port.
module tlb_pipe #(
   parameter int unsigned TLBNUM = 16,
   localparam int unsigned IW = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          reset,
   // search port 0 (fetch)
   input  logic          s0_req,
   input  logic [18:0]   s0_vppn,
   input  logic          s0_va_bit12,
   input  logic [9:0]    s0_asid,
   output logic          s0_resp_valid,
   output logic          s0_found,
   output logic          s0_multi,
   output logic [IW-1:0] s0_index,
   output logic [19:0]   s0_ppn,
   output logic [5:0]    s0_ps,
   output logic [1:0]    s0_plv,
   output logic [1:0]    s0_mat,
   output logic          s0_d,
   output logic          s0_v,
   // search port 1 (load/store/TLBSRCH)
   input  logic          s1_req,
   input  logic [18:0]   s1_vppn,
   input  logic          s1_va_bit12,
   input  logic [9:0]    s1_asid,
   output logic          s1_resp_valid,
   output logic          s1_found,
   output logic          s1_multi,
   output logic [IW-1:0] s1_index,
   output logic [19:0]   s1_ppn,
   output logic [5:0]    s1_ps,
   output logic [1:0]    s1_plv,
   output logic [1:0]    s1_mat,
   output logic          s1_d,
   output logic          s1_v,
   // invalidate
   input  logic          invtlb_valid,
   input  logic [4:0]    invtlb_op,
   input  logic [9:0]    invtlb_asid,
   input  logic [18:0]   invtlb_vppn,
   output logic          inv_err,
   // write
   input  logic          we,
   input  logic          w_fill,
   input  logic [IW-1:0] w_index,
   input  logic          w_e,
   input  logic [5:0]    w_ps,
   input  logic [18:0]   w_vppn,
   input  logic [9:0]    w_asid,
   input  logic          w_g,
   input  logic [19:0]   w_ppn0,
   input  logic [1:0]    w_plv0,
   input  logic [1:0]    w_mat0,
   input  logic          w_d0,
   input  logic          w_v0,
   input  logic [19:0]   w_ppn1,
   input  logic [1:0]    w_plv1,
   input  logic [1:0]    w_mat1,
   input  logic          w_d1,
   input  logic          w_v1,
   output logic [IW-1:0] fill_index,
   // read
   input  logic [IW-1:0] r_index,
   output logic          r_e,
   output logic [18:0]   r_vppn,
   output logic [5:0]    r_ps,
   output logic [9:0]    r_asid,
   output logic          r_g,
   output logic [19:0]   r_ppn0,
   output logic [1:0]    r_plv0,
   output logic [1:0]    r_mat0,
   output logic          r_d0,
   output logic          r_v0,
   output logic [19:0]   r_ppn1,
   output logic [1:0]    r_plv1,
   output logic [1:0]    r_mat1,
   output logic          r_d1,
   output logic          r_v1
);

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } page_t;

   typedef struct packed {
      logic          found;
      logic          multi;
      logic [IW-1:0] index;
      logic [5:0]    ps;
      page_t         pg;
   } srch_t;

   logic [TLBNUM-1:0] e_q;
   logic              ps4mb_q [TLBNUM];
   logic [18:0]       vppn_q  [TLBNUM];
   logic [9:0]        asid_q  [TLBNUM];
   logic              g_q     [TLBNUM];
   page_t             page0_q [TLBNUM];
   page_t             page1_q [TLBNUM];

   logic [IW-1:0]     fill_q;
   logic [IW-1:0]     widx;
   logic [TLBNUM-1:0] inv_hit;
   logic [1:0][18:0]  k_vppn;
   logic [1:0][9:0]   k_asid;
   logic [1:0]        k_bit12;
   logic [1:0]        k_req;
   srch_t [1:0]       hit_c;
   srch_t [1:0]       res_q;
   logic [1:0]        rv_q;
   logic              inv_err_q;

   // Page-size-aware VPPN compare: 4MB pages ignore vppn[9:0].
   function automatic logic vppn_hit(input logic ps4mb, input logic [18:0] a,
                                     input logic [18:0] b);
      return (a[18:10] == b[18:10]) && (ps4mb || (a[9:0] == b[9:0]));
   endfunction

   assign widx    = w_fill ? fill_q : w_index;
   assign k_vppn  = {s1_vppn, s0_vppn};
   assign k_asid  = {s1_asid, s0_asid};
   assign k_bit12 = {s1_va_bit12, s0_va_bit12};
   assign k_req   = {s1_req, s0_req};

   // Entry selection for each INVTLB op; ops above 6 select nothing.
   always_comb begin
      inv_hit = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         case (invtlb_op)
            5'd0, 5'd1: inv_hit[i] = 1'b1;
            5'd2:       inv_hit[i] = g_q[i];
            5'd3:       inv_hit[i] = !g_q[i];
            5'd4:       inv_hit[i] = !g_q[i] && (asid_q[i] == invtlb_asid);
            5'd5:       inv_hit[i] = !g_q[i] && (asid_q[i] == invtlb_asid) &&
                                     vppn_hit(ps4mb_q[i], vppn_q[i], invtlb_vppn);
            5'd6:       inv_hit[i] = (g_q[i] || (asid_q[i] == invtlb_asid)) &&
                                     vppn_hit(ps4mb_q[i], vppn_q[i], invtlb_vppn);
            default:    inv_hit[i] = 1'b0;
         endcase
      end
   end

   // Associative search; the lowest matching index supplies the result.
   always_comb begin
      hit_c = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < TLBNUM; i++) begin
            if (e_q[i] && vppn_hit(ps4mb_q[i], vppn_q[i], k_vppn[p]) &&
                (g_q[i] || (asid_q[i] == k_asid[p]))) begin
               if (!hit_c[p].found) begin
                  hit_c[p].found = 1'b1;
                  hit_c[p].index = IW'(i);
                  hit_c[p].ps    = ps4mb_q[i] ? 6'd22 : 6'd12;
                  if (ps4mb_q[i] ? k_vppn[p][9] : k_bit12[p])
                     hit_c[p].pg = page1_q[i];
                  else
                     hit_c[p].pg = page0_q[i];
               end else begin
                  hit_c[p].multi = 1'b1;
               end
            end
         end
      end
   end

   // Search result registers; results hold while a port is idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rv_q  <= '0;
         res_q <= '0;
      end else begin
         rv_q <= k_req;
         for (int p = 0; p < 2; p++)
            if (k_req[p]) res_q[p] <= hit_c[p];
      end
   end

   // Valid bits: a write to an index overrides a concurrent invalidate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q       <= '0;
         fill_q    <= '0;
         inv_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < TLBNUM; i++) begin
            if (we && (widx == IW'(i)))
               e_q[i] <= w_e;
            else if (invtlb_valid && inv_hit[i])
               e_q[i] <= 1'b0;
         end
         if (we && w_fill) fill_q <= fill_q + IW'(1);
         inv_err_q <= invtlb_valid && (invtlb_op > 5'd6);
      end
   end

   // Entry payload is not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         ps4mb_q[widx] <= (w_ps == 6'd22);
         vppn_q[widx]  <= w_vppn;
         asid_q[widx]  <= w_asid;
         g_q[widx]     <= w_g;
         page0_q[widx] <= '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0};
         page1_q[widx] <= '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1};
      end
   end

   assign s0_resp_valid = rv_q[0];
   assign s0_found      = res_q[0].found;
   assign s0_multi      = res_q[0].multi;
   assign s0_index      = res_q[0].index;
   assign s0_ps         = res_q[0].ps;
   assign s0_ppn        = res_q[0].pg.ppn;
   assign s0_plv        = res_q[0].pg.plv;
   assign s0_mat        = res_q[0].pg.mat;
   assign s0_d          = res_q[0].pg.d;
   assign s0_v          = res_q[0].pg.v;

   assign s1_resp_valid = rv_q[1];
   assign s1_found      = res_q[1].found;
   assign s1_multi      = res_q[1].multi;
   assign s1_index      = res_q[1].index;
   assign s1_ps         = res_q[1].ps;
   assign s1_ppn        = res_q[1].pg.ppn;
   assign s1_plv        = res_q[1].pg.plv;
   assign s1_mat        = res_q[1].pg.mat;
   assign s1_d          = res_q[1].pg.d;
   assign s1_v          = res_q[1].pg.v;

   assign inv_err    = inv_err_q;
   assign fill_index = fill_q;

   assign r_e    = e_q[r_index];
   assign r_vppn = vppn_q[r_index];
   assign r_ps   = ps4mb_q[r_index] ? 6'd22 : 6'd12;
   assign r_asid = asid_q[r_index];
   assign r_g    = g_q[r_index];
   assign r_ppn0 = page0_q[r_index].ppn;
   assign r_plv0 = page0_q[r_index].plv;
   assign r_mat0 = page0_q[r_index].mat;
   assign r_d0   = page0_q[r_index].d;
   assign r_v0   = page0_q[r_index].v;
   assign r_ppn1 = page1_q[r_index].ppn;
   assign r_plv1 = page1_q[r_index].plv;
   assign r_mat1 = page1_q[r_index].mat;
   assign r_d1   = page1_q[r_index].d;
   assign r_v1   = page1_q[r_index].v;

endmodule

// File: tb/tb_tlb_pipe.sv
// Directed bench for tlb_pipe: search, half select, multi-hit, INVTLB, fill,
// write/invalidate/search conflicts and asynchronous reset.
module tb_tlb_pipe;
   localparam int unsigned TLBNUM = 16;
   localparam int unsigned IW = 4;

   logic clk, reset;
   logic s0_req, s0_va_bit12, s1_req, s1_va_bit12;
   logic [18:0] s0_vppn, s1_vppn;
   logic [9:0]  s0_asid, s1_asid;
   logic s0_resp_valid, s0_found, s0_multi, s0_d, s0_v;
   logic s1_resp_valid, s1_found, s1_multi, s1_d, s1_v;
   logic [IW-1:0] s0_index, s1_index;
   logic [19:0] s0_ppn, s1_ppn;
   logic [5:0]  s0_ps, s1_ps;
   logic [1:0]  s0_plv, s0_mat, s1_plv, s1_mat;
   logic invtlb_valid, inv_err;
   logic [4:0]  invtlb_op;
   logic [9:0]  invtlb_asid;
   logic [18:0] invtlb_vppn;
   logic we, w_fill, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [IW-1:0] w_index, fill_index, r_index;
   logic [5:0]  w_ps, r_ps;
   logic [18:0] w_vppn, r_vppn;
   logic [9:0]  w_asid, r_asid;
   logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
   logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
   logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;

   int n_checks = 0;
   int n_fail = 0;

   tlb_pipe #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .reset(reset),
      .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
      .s0_resp_valid(s0_resp_valid), .s0_found(s0_found), .s0_multi(s0_multi),
      .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps), .s0_plv(s0_plv),
      .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
      .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_resp_valid(s1_resp_valid), .s1_found(s1_found), .s1_multi(s1_multi),
      .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps), .s1_plv(s1_plv),
      .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
      .invtlb_vppn(invtlb_vppn), .inv_err(inv_err),
      .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e), .w_ps(w_ps),
      .w_vppn(w_vppn), .w_asid(w_asid), .w_g(w_g),
      .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
      .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
      .fill_index(fill_index), .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn),
      .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
      .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
      .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int idx, input logic fill, input logic e,
                           input logic [5:0] ps, input logic [18:0] vppn,
                           input logic [9:0] asid, input logic g,
                           input logic [19:0] ppn0, input logic [19:0] ppn1);
      we = 1'b1; w_fill = fill; w_index = IW'(idx); w_e = e; w_ps = ps;
      w_vppn = vppn; w_asid = asid; w_g = g; w_ppn0 = ppn0; w_ppn1 = ppn1;
      w_plv0 = 2'd1; w_plv1 = 2'd2; w_mat0 = 2'd1; w_mat1 = 2'd2;
      w_d0 = 1'b0; w_v0 = 1'b1; w_d1 = 1'b1; w_v1 = 1'b1;
      tick();
      we = 1'b0; w_fill = 1'b0;
   endtask

   task automatic do_inv(input logic [4:0] op, input logic [9:0] asid,
                         input logic [18:0] vppn);
      invtlb_valid = 1'b1; invtlb_op = op; invtlb_asid = asid; invtlb_vppn = vppn;
      tick();
      invtlb_valid = 1'b0;
   endtask

   task automatic search(input int port, input logic [18:0] vppn,
                         input logic [9:0] asid, input logic bit12);
      if (port == 0) begin
         s0_req = 1'b1; s0_vppn = vppn; s0_asid = asid; s0_va_bit12 = bit12;
      end else begin
         s1_req = 1'b1; s1_vppn = vppn; s1_asid = asid; s1_va_bit12 = bit12;
      end
      tick();
      s0_req = 1'b0; s1_req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      s0_req = 1'b1; s0_vppn = 19'h12345; s0_asid = 10'd1; s0_va_bit12 = 1'b0;
      tick(); tick();
      n_checks++;
      if (s0_resp_valid !== 1'b0 || inv_err !== 1'b0 || fill_index !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_state: rv=%b inv_err=%b fill=%0d, required 0 0 0",
                  s0_resp_valid, inv_err, fill_index);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (s0_resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_rv: got %b required 0", s0_resp_valid);
      end
      tick();
      s0_req = 1'b0;
      n_checks++;
      if (s0_resp_valid !== 1'b1 || s0_found !== 1'b0 || s0_index !== 4'd0 ||
          s0_ppn !== 20'h0 || s0_multi !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_miss: rv=%b found=%b idx=%0d ppn=%h multi=%b, required 1 0 0 0 0",
                  s0_resp_valid, s0_found, s0_index, s0_ppn, s0_multi);
      end
      for (int i = 0; i < TLBNUM; i++) begin
         r_index = IW'(i);
         #1;
         n_checks++;
         if (r_e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_r_e[%0d]: got %b required 0", i, r_e);
         end
      end
   endtask

   task automatic test_4kb();
      do_write(3, 1'b0, 1'b1, 6'd12, 19'h00100, 10'd5, 1'b0, 20'hAAAAA, 20'hBBBBB);
      search(1, 19'h00100, 10'd5, 1'b1);
      n_checks++;
      if (s1_resp_valid !== 1'b1 || s1_found !== 1'b1 || s1_index !== 4'd3 ||
          s1_ppn !== 20'hBBBBB || s1_ps !== 6'd12 || s1_plv !== 2'd2 || s1_multi !== 1'b0) begin
         n_fail++;
         $display("FAIL 4kb_odd: rv=%b f=%b idx=%0d ppn=%h ps=%0d plv=%0d m=%b, required 1 1 3 bbbbb 12 2 0",
                  s1_resp_valid, s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_multi);
      end
      tick();
      n_checks++;
      if (s1_resp_valid !== 1'b0 || s1_index !== 4'd3 || s1_found !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_hold: rv=%b idx=%0d found=%b, required 0 3 1",
                  s1_resp_valid, s1_index, s1_found);
      end
      search(1, 19'h00100, 10'd5, 1'b0);
      n_checks++;
      if (s1_found !== 1'b1 || s1_ppn !== 20'hAAAAA || s1_plv !== 2'd1) begin
         n_fail++;
         $display("FAIL 4kb_even: f=%b ppn=%h plv=%0d, required 1 aaaaa 1", s1_found, s1_ppn, s1_plv);
      end
      search(1, 19'h00100, 10'd6, 1'b1);
      n_checks++;
      if (s1_found !== 1'b0 || s1_ppn !== 20'h0 || s1_ps !== 6'd0 || s1_index !== 4'd0) begin
         n_fail++;
         $display("FAIL 4kb_asid_miss: f=%b ppn=%h ps=%0d idx=%0d, required 0 0 0 0",
                  s1_found, s1_ppn, s1_ps, s1_index);
      end
   endtask

   task automatic test_4mb_multi();
      do_write(1, 1'b0, 1'b1, 6'd22, 19'h00200, 10'd0, 1'b1, 20'h11111, 20'h22222);
      do_write(7, 1'b0, 1'b1, 6'd22, 19'h00200, 10'd0, 1'b1, 20'h11111, 20'h22222);
      search(0, 19'h001FF, 10'h3AB, 1'b1);
      n_checks++;
      if (s0_found !== 1'b1 || s0_multi !== 1'b1 || s0_index !== 4'd1 ||
          s0_ppn !== 20'h11111 || s0_ps !== 6'd22) begin
         n_fail++;
         $display("FAIL 4mb_even_multi: f=%b m=%b idx=%0d ppn=%h ps=%0d, required 1 1 1 11111 22",
                  s0_found, s0_multi, s0_index, s0_ppn, s0_ps);
      end
      search(0, 19'h00300, 10'h001, 1'b0);
      n_checks++;
      if (s0_found !== 1'b1 || s0_ppn !== 20'h22222 || s0_index !== 4'd1) begin
         n_fail++;
         $display("FAIL 4mb_odd: f=%b ppn=%h idx=%0d, required 1 22222 1", s0_found, s0_ppn, s0_index);
      end
   endtask

   task automatic test_invtlb();
      do_inv(5'd4, 10'd5, 19'h0);
      r_index = 4'd3; #1;
      n_checks++;
      if (r_e !== 1'b0) begin
         n_fail++; $display("FAIL inv4_e3: got %b required 0", r_e);
      end
      r_index = 4'd1; #1;
      n_checks++;
      if (r_e !== 1'b1) begin
         n_fail++; $display("FAIL inv4_e1: got %b required 1", r_e);
      end
      do_inv(5'd2, 10'd0, 19'h0);
      r_index = 4'd1; #1;
      n_checks++;
      if (r_e !== 1'b0) begin
         n_fail++; $display("FAIL inv2_e1: got %b required 0", r_e);
      end
      r_index = 4'd7; #1;
      n_checks++;
      if (r_e !== 1'b0) begin
         n_fail++; $display("FAIL inv2_e7: got %b required 0", r_e);
      end
      do_write(3, 1'b0, 1'b1, 6'd12, 19'h00100, 10'd5, 1'b0, 20'hAAAAA, 20'hBBBBB);
      do_inv(5'd5, 10'd5, 19'h00101);
      r_index = 4'd3; #1;
      n_checks++;
      if (r_e !== 1'b1) begin
         n_fail++; $display("FAIL inv5_vppn_mismatch: got %b required 1", r_e);
      end
      do_inv(5'd6, 10'd5, 19'h00100);
      n_checks++;
      if (r_e !== 1'b0) begin
         n_fail++; $display("FAIL inv6_e3: got %b required 0", r_e);
      end
      do_write(3, 1'b0, 1'b1, 6'd12, 19'h00100, 10'd5, 1'b0, 20'hAAAAA, 20'hBBBBB);
      do_inv(5'd9, 10'd5, 19'h00100);
      n_checks++;
      if (inv_err !== 1'b1) begin
         n_fail++; $display("FAIL inv9_err_pulse: got %b required 1", inv_err);
      end
      tick();
      n_checks++;
      if (inv_err !== 1'b0 || r_e !== 1'b1) begin
         n_fail++; $display("FAIL inv9_after: inv_err=%b e3=%b, required 0 1", inv_err, r_e);
      end
   endtask

   task automatic test_conflict();
      do_write(5, 1'b0, 1'b1, 6'd12, 19'h00007, 10'd2, 1'b1, 20'h0, 20'h0);
      we = 1'b1; w_fill = 1'b0; w_index = 4'd5; w_e = 1'b1; w_ps = 6'd12;
      w_vppn = 19'h04567; w_asid = 10'd8; w_g = 1'b0; w_ppn0 = 20'h55555; w_ppn1 = 20'h66666;
      s0_req = 1'b1; s0_vppn = 19'h04567; s0_asid = 10'd8; s0_va_bit12 = 1'b0;
      invtlb_valid = 1'b1; invtlb_op = 5'd0;
      tick();
      we = 1'b0; s0_req = 1'b0; invtlb_valid = 1'b0;
      n_checks++;
      if (s0_resp_valid !== 1'b1 || s0_found !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_pre_update: rv=%b found=%b, required 1 0", s0_resp_valid, s0_found);
      end
      for (int i = 0; i < TLBNUM; i++) begin
         r_index = IW'(i);
         #1;
         n_checks++;
         if (r_e !== (i == 5)) begin
            n_fail++; $display("FAIL conflict_r_e[%0d]: got %b required %b", i, r_e, (i == 5));
         end
      end
      search(0, 19'h04567, 10'd8, 1'b0);
      n_checks++;
      if (s0_found !== 1'b1 || s0_index !== 4'd5 || s0_ppn !== 20'h55555) begin
         n_fail++;
         $display("FAIL conflict_next_hit: f=%b idx=%0d ppn=%h, required 1 5 55555",
                  s0_found, s0_index, s0_ppn);
      end
   endtask

   task automatic test_fill();
      n_checks++;
      if (fill_index !== 4'd0) begin
         n_fail++; $display("FAIL fill_start: got %0d required 0", fill_index);
      end
      for (int i = 0; i < TLBNUM; i++) begin
         do_write((i + 7) % TLBNUM, 1'b1, 1'b1, 6'd12, 19'(i), 10'd0, 1'b1,
                  20'h00100 + 20'(i), 20'h00200 + 20'(i));
         n_checks++;
         if (fill_index !== IW'((i + 1) % TLBNUM)) begin
            n_fail++;
            $display("FAIL fill_advance[%0d]: got %0d required %0d", i, fill_index, (i + 1) % TLBNUM);
         end
      end
      for (int i = 0; i < TLBNUM; i++) begin
         r_index = IW'(i);
         #1;
         n_checks++;
         if (r_e !== 1'b1 || r_vppn !== 19'(i)) begin
            n_fail++;
            $display("FAIL fill_order[%0d]: e=%b vppn=%h, required 1 %h", i, r_e, r_vppn, i);
         end
      end
      do_write(2, 1'b0, 1'b1, 6'd12, 19'h00222, 10'd0, 1'b1, 20'h0, 20'h0);
      r_index = 4'd2; #1;
      n_checks++;
      if (fill_index !== 4'd0 || r_vppn !== 19'h00222) begin
         n_fail++;
         $display("FAIL nofill_write: fill=%0d vppn=%h, required 0 00222", fill_index, r_vppn);
      end
   endtask

   task automatic test_back_to_back();
      s0_req = 1'b1; s0_vppn = 19'd3; s0_asid = 10'd9; s0_va_bit12 = 1'b0;
      s1_req = 1'b1; s1_vppn = 19'd10; s1_asid = 10'd4; s1_va_bit12 = 1'b1;
      tick();
      s1_req = 1'b0;
      n_checks++;
      if (s0_index !== 4'd3 || s0_ppn !== 20'h00103 || s1_index !== 4'd10 ||
          s1_ppn !== 20'h0020A || s1_resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL dual_port: i0=%0d p0=%h i1=%0d p1=%h rv1=%b, required 3 00103 10 0020a 1",
                  s0_index, s0_ppn, s1_index, s1_ppn, s1_resp_valid);
      end
      s0_vppn = 19'd4;
      tick();
      s0_req = 1'b0;
      n_checks++;
      if (s0_resp_valid !== 1'b1 || s0_index !== 4'd4 || s1_resp_valid !== 1'b0 ||
          s1_index !== 4'd10) begin
         n_fail++;
         $display("FAIL back_to_back: rv0=%b i0=%0d rv1=%b i1=%0d, required 1 4 0 10",
                  s0_resp_valid, s0_index, s1_resp_valid, s1_index);
      end
   endtask

   task automatic test_reset_mid_search();
      s0_req = 1'b1; s0_vppn = 19'd5; s0_asid = 10'd0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (s0_resp_valid !== 1'b0 || s0_found !== 1'b0 || fill_index !== 4'd0) begin
         n_fail++;
         $display("FAIL async_reset: rv=%b found=%b fill=%0d, required 0 0 0",
                  s0_resp_valid, s0_found, fill_index);
      end
      tick();
      @(negedge clk);
      reset = 1'b0;
      #1;
      r_index = 4'd5; #1;
      n_checks++;
      if (s0_resp_valid !== 1'b0 || r_e !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_drop: rv=%b e5=%b, required 0 0", s0_resp_valid, r_e);
      end
      s0_req = 1'b0;
   endtask

   initial begin
      s0_req = 1'b0; s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
      s1_req = 1'b0; s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
      invtlb_valid = 1'b0; invtlb_op = '0; invtlb_asid = '0; invtlb_vppn = '0;
      we = 1'b0; w_fill = 1'b0; w_index = '0; w_e = 1'b0; w_ps = '0; w_vppn = '0;
      w_asid = '0; w_g = 1'b0; w_ppn0 = '0; w_ppn1 = '0; w_plv0 = '0; w_plv1 = '0;
      w_mat0 = '0; w_mat1 = '0; w_d0 = 1'b0; w_d1 = 1'b0; w_v0 = 1'b0; w_v1 = 1'b0;
      r_index = '0;
      test_reset();
      test_4kb();
      test_4mb_multi();
      test_invtlb();
      test_conflict();
      test_fill();
      test_back_to_back();
      test_reset_mid_search();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
